udma_ext_per_stream_checker: RTL and testbench
==============================================

Name: udma_ext_per_stream_checker

Overview:
- Stream sink that sits directly downstream of the uDMA external-peripheral TX dual-clock path, in the peripheral clock domain.
- Consumes the 32-bit TX word stream and checks each word against a locally generated expected sequence (incrementing counter or LFSR).
- Reports busy, sticky error, word and error counts, and the first mismatch to the external-peripheral status/setup registers.

Parameters:
- CNT_W, 16, width of word/error/index counters (all saturate).
- SEED, 32'h0000_0001, first expected word after each start; must be nonzero for LFSR mode.

Ports:
- clk_i  in  1  peripheral clock; all logic on rising edge.
- rst_i  in  1  synchronous reset, active high.
- cfg_setup_i  in  32  [0] en, [1] mode (0 = incr, 1 = LFSR), [2] stop_on_err, [3] clr, [11:4] stall_period (feature only), others ignored.
- tx_data_i  in  32  stream data.
- tx_valid_i  in  1  stream valid.
- tx_ready_o  out  1  stream ready.
- busy_o  out  1  high when state != IDLE.
- err_o  out  1  sticky mismatch flag.
- word_cnt_o  out  CNT_W  words accepted.
- err_cnt_o  out  CNT_W  mismatching words.
- first_err_idx_o  out  CNT_W  word_cnt value at the first mismatch.
- first_err_data_o  out  32  received data at the first mismatch.

Behaviour:
- Reset: state = IDLE, tx_ready_o = 0, busy_o = 0, err_o = 0, all counters and captures = 0, expected = SEED, latched mode = 0.
- Transfer: tx_valid_i && tx_ready_o in the same cycle. tx_ready_o is combinational from registered state only and never depends on tx_valid_i.
- FSM states:
  - IDLE: ready = 0. en = 1 moves to RUN next cycle, loads expected = SEED and latches mode. Counters are not cleared.
  - RUN: ready = 1, unless the optional stall is active. en = 0 moves to IDLE next cycle; a transfer in that same cycle still counts. A mismatch with stop_on_err = 1 moves to HALT next cycle.
  - HALT: ready = 0. Leaves to IDLE only when en = 0.
- Per transfer:
  - Compare tx_data_i with expected.
  - word_cnt++ (saturates at all-ones).
  - On mismatch: err_cnt++ (saturating) and err_o set. If err_o was 0 before this cycle, capture first_err_idx = word_cnt (pre-increment) and first_err_data = tx_data_i.
  - expected advances from its own value, never resynced to received data:
    - incr mode: expected + 1, mod 2^32 (0xFFFF_FFFF wraps to 0).
    - LFSR mode: Galois right-shift, polynomial x^32 + x^22 + x^2 + x + 1, mask 32'h8020_0003 XORed when the shifted-out LSB is 1.
- clr (level):
  - In IDLE or HALT: clears counters, captures and err_o; takes priority over other updates.
  - In RUN: ignored.
- cfg mode changes during RUN/HALT are ignored until the next start.
- Latency: compare result is visible on err_o / err_cnt_o one cycle after the transfer.
- Reset mid-transfer: immediate return to reset values on the next edge; the in-flight word is dropped and not counted.

Optional Feature:
- Macro UDMA_EXT_PER_CHK_STALL_EN.
- When defined:
  - An 8-bit stall counter runs in RUN.
  - If stall_period != 0, tx_ready_o is deasserted for exactly one cycle every stall_period + 1 RUN cycles (first stall on cycle stall_period after entering RUN); stall_period = 0 means no stalls.
  - The counter resets on entering RUN.
- When undefined: no stall logic; cfg_setup_i[11:4] ignored; ready = 1 throughout RUN.

Decomposition:
- Package udma_ext_per_chk_pkg holds:
  - state enum (IDLE, RUN, HALT);
  - cfg bit-index localparams (CFG_EN, CFG_MODE, CFG_STOP, CFG_CLR, CFG_STALL_LSB/MSB);
  - LFSR_MASK = 32'h8020_0003;
  - function lfsr_next.
- One sub-module: udma_ext_per_chk_patgen (expected-value register with load/advance/mode); the top holds FSM, counters and captures.

Test Plan:
- Incr mode, SEED = 1, en = 1, send 1..100 back-to-back -> word_cnt = 100, err_cnt = 0, err_o = 0, busy_o = 1.
- LFSR mode, SEED = 1, send 8 correct LFSR words with word 5 XOR 1 -> err_cnt = 1, first_err_idx = 5, first_err_data = corrupted value, state stays RUN.
- stop_on_err = 1, mismatch at word 3 -> HALT next cycle, tx_ready_o = 0, word_cnt = 4; en = 0 -> IDLE; clr = 1 -> all counters 0, err_o = 0.
- Incr mode, SEED = 32'hFFFF_FFFE, send FFFF_FFFE, FFFF_FFFF, 0, 1 -> no errors (wrap). CNT_W = 4: send 20 words -> word_cnt = 15 (saturated).
- en dropped in a cycle with a valid transfer -> that word is counted, ready = 0 next cycle. rst_i pulse mid-stream -> all outputs return to reset values.
- With UDMA_EXT_PER_CHK_STALL_EN, stall_period = 3, valid held high for 16 cycles -> ready low on RUN cycles 3, 7, 11, 15; word_cnt = 12, err_cnt = 0.

Source files
------------

// File: rtl/udma_ext_per_chk_pkg.sv
// Shared types and constants for the uDMA external-peripheral TX stream checker.
package udma_ext_per_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } chk_state_e;

  // Bit positions inside cfg_setup_i
  localparam int CFG_EN        = 0;
  localparam int CFG_MODE      = 1;
  localparam int CFG_STOP      = 2;
  localparam int CFG_CLR       = 3;
  localparam int CFG_STALL_LSB = 4;
  localparam int CFG_STALL_MSB = 11;

  // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    lfsr_next = (cur >> 1) ^ (cur[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/udma_ext_per_chk_patgen.sv
// Expected-word generator: reloads SEED and latches the mode on start,
// then steps once per accepted word (counter or LFSR). It never resyncs
// to received data, so a single corrupted word causes a single mismatch.
module udma_ext_per_chk_patgen
  import udma_ext_per_chk_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        load_mode,
  input  logic        advance,
  output logic [31:0] expected
);

  logic mode_q;

  // Expected value and latched mode register
  always_ff @(posedge clk) begin
    if (rst) begin
      expected <= SEED;
      mode_q   <= 1'b0;
    end else if (load) begin
      expected <= SEED;
      mode_q   <= load_mode;
    end else if (advance) begin
      expected <= mode_q ? lfsr_next(expected) : expected + 32'd1;
    end
  end

endmodule

// File: rtl/udma_ext_per_stream_checker.sv
// Stream sink checking the uDMA external-peripheral TX word stream against
// a locally generated expected sequence, reporting counts and first error.
// Optional macro UDMA_EXT_PER_CHK_STALL_EN adds periodic one-cycle ready stalls.
//
// Handshake: a word transfers when tx_valid_i && tx_ready_o on a rising
// edge; tx_ready_o is decoded from registered state only, never from
// tx_valid_i, so the upstream source may hold valid and data until accepted.
module udma_ext_per_stream_checker
  import udma_ext_per_chk_pkg::*;
#(
  parameter int          CNT_W = 16,
  parameter logic [31:0] SEED  = 32'h0000_0001
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      cfg_setup_i,
  input  logic [31:0]      tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [CNT_W-1:0] word_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] first_err_idx_o,
  output logic [31:0]      first_err_data_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  chk_state_e  state_q, state_d;
  logic        cfg_en, cfg_mode, cfg_stop, cfg_clr;
  logic        load, xfer, mismatch, stall;
  logic [31:0] expected;

  assign cfg_en   = cfg_setup_i[CFG_EN];
  assign cfg_mode = cfg_setup_i[CFG_MODE];
  assign cfg_stop = cfg_setup_i[CFG_STOP];
  assign cfg_clr  = cfg_setup_i[CFG_CLR];

`ifdef UDMA_EXT_PER_CHK_STALL_EN
  logic [7:0] stall_period;
  logic [7:0] stall_cnt_q;
  logic       cfg_unused;

  assign stall_period = cfg_setup_i[CFG_STALL_MSB:CFG_STALL_LSB];
  assign cfg_unused   = ^cfg_setup_i[31:CFG_STALL_MSB+1];
  assign stall        = (state_q == ST_RUN) && (stall_period != 8'd0) &&
                        (stall_cnt_q >= stall_period);

  // RUN-cycle counter; held at zero outside RUN so each start begins fresh
  always_ff @(posedge clk_i) begin
    if (rst_i || state_q != ST_RUN || stall || stall_period == 8'd0) begin
      stall_cnt_q <= 8'd0;
    end else begin
      stall_cnt_q <= stall_cnt_q + 8'd1;
    end
  end
`else
  logic cfg_unused;

  assign cfg_unused = ^cfg_setup_i[31:CFG_CLR+1];
  assign stall      = 1'b0;
`endif

  assign tx_ready_o = (state_q == ST_RUN) && !stall;
  assign busy_o     = (state_q != ST_IDLE);
  assign xfer       = tx_valid_i && tx_ready_o;
  assign mismatch   = xfer && (tx_data_i != expected);

  udma_ext_per_chk_patgen #(
    .SEED (SEED)
  ) u_patgen (
    .clk       (clk_i),
    .rst       (rst_i),
    .load      (load),
    .load_mode (cfg_mode),
    .advance   (xfer),
    .expected  (expected)
  );

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; the generator reloads on every IDLE -> RUN start
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_en) begin
          state_d = ST_RUN;
          load    = 1'b1;
        end
      end
      ST_RUN: begin
        if (!cfg_en)                   state_d = ST_IDLE;
        else if (mismatch && cfg_stop) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (!cfg_en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counters, sticky error and first-mismatch capture; clr outside RUN wins
  always_ff @(posedge clk_i) begin
    if (rst_i || (cfg_clr && state_q != ST_RUN)) begin
      word_cnt_o       <= '0;
      err_cnt_o        <= '0;
      err_o            <= 1'b0;
      first_err_idx_o  <= '0;
      first_err_data_o <= 32'd0;
    end else if (xfer) begin
      if (word_cnt_o != CNT_MAX) word_cnt_o <= word_cnt_o + CNT_ONE;
      if (mismatch) begin
        if (err_cnt_o != CNT_MAX) err_cnt_o <= err_cnt_o + CNT_ONE;
        err_o <= 1'b1;
        if (!err_o) begin
          first_err_idx_o  <= word_cnt_o;
          first_err_data_o <= tx_data_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_udma_ext_per_stream_checker.sv
// Self-checking bench for udma_ext_per_stream_checker: directed sequences,
// a table-driven wrap/saturation run and a randomized run against a model.
module tb_udma_ext_per_stream_checker;

  logic        clk = 1'b0;
  logic        rst;

  // Main instance: CNT_W = 16, SEED = 1
  logic [31:0] cfg, data;
  logic        valid, ready, busy, err;
  logic [15:0] wc, ec, fidx;
  logic [31:0] fdata;

  // Second instance: CNT_W = 4, SEED = 0xFFFF_FFFE (wrap + saturation)
  logic [31:0] cfg4, data4;
  logic        valid4, ready4, busy4, err4;
  logic [3:0]  wc4, ec4, fidx4;
  logic [31:0] fdata4;

  int vec_cnt = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  exp_wc;
  } vec_t;
  vec_t tbl[20];

  logic [31:0] exp_q[$];

  udma_ext_per_stream_checker dut (
    .clk_i(clk), .rst_i(rst), .cfg_setup_i(cfg), .tx_data_i(data),
    .tx_valid_i(valid), .tx_ready_o(ready), .busy_o(busy), .err_o(err),
    .word_cnt_o(wc), .err_cnt_o(ec), .first_err_idx_o(fidx),
    .first_err_data_o(fdata)
  );

  udma_ext_per_stream_checker #(.CNT_W(4), .SEED(32'hFFFF_FFFE)) dut4 (
    .clk_i(clk), .rst_i(rst), .cfg_setup_i(cfg4), .tx_data_i(data4),
    .tx_valid_i(valid4), .tx_ready_o(ready4), .busy_o(busy4), .err_o(err4),
    .word_cnt_o(wc4), .err_cnt_o(ec4), .first_err_idx_o(fidx4),
    .first_err_data_o(fdata4)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_cfg(input logic en, input logic mode, input logic stop,
                                         input logic clr, input logic [7:0] stall);
    return {20'd0, stall, clr, stop, mode, en};
  endfunction

  // Reference LFSR step written from the polynomial description
  function automatic logic [31:0] ref_lfsr(input logic [31:0] v);
    logic lsb;
    lsb = v[0];
    v = v >> 1;
    if (lsb) v = v ^ 32'h8020_0003;
    return v;
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic idle_and_clear();
    valid = 1'b0;
    cfg = mk_cfg(0, 0, 0, 0, 0); tick();
    cfg = mk_cfg(0, 0, 0, 1, 0); tick();
    cfg = mk_cfg(0, 0, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(ready), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_err"},   32'(err), 0);
    check({tag, "_wc"},    32'(wc), 0);
    check({tag, "_ec"},    32'(ec), 0);
    check({tag, "_fidx"},  32'(fidx), 0);
    check({tag, "_fdata"}, fdata, 0);
  endtask

  initial begin
    logic [31:0] w, bad;
    int m_wc, m_ec, m_fidx, acc;
    logic m_err, mode, exp_rdy;
    logic [31:0] m_fdata, e;

    for (int i = 0; i < 20; i++) begin
      tbl[i].data   = 32'hFFFF_FFFE + 32'(i);
      tbl[i].exp_wc = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
    end

    // ---------------- reset ----------------
    rst = 1'b1; cfg = 0; data = 0; valid = 0; cfg4 = 0; data4 = 0; valid4 = 0;
    tick(); tick();
    rst = 1'b0;
    check_all_zero("rst");
    check("rst4_ready", 32'(ready4), 0);
    check("rst4_wc", 32'(wc4), 0);

    // ---------------- incrementing, 1..100 ----------------
    cfg = mk_cfg(1, 0, 0, 0, 0); tick();
    check("incr_busy_start", 32'(busy), 1);
    check("incr_ready_start", 32'(ready), 1);
    for (int i = 1; i <= 100; i++) begin
      data = 32'(i); valid = 1'b1; tick();
    end
    valid = 1'b0;
    check("incr_wc", 32'(wc), 100);
    check("incr_ec", 32'(ec), 0);
    check("incr_err", 32'(err), 0);
    check("incr_busy", 32'(busy), 1);
    cfg = mk_cfg(0, 0, 0, 0, 0); tick();
    check("incr_stop_busy", 32'(busy), 0);
    check("incr_stop_ready", 32'(ready), 0);
    check("incr_kept_wc", 32'(wc), 100);
    idle_and_clear();
    check("clr_wc", 32'(wc), 0);

    // ---------------- LFSR, word 5 corrupted ----------------
    w = 32'd1; bad = 0;
    cfg = mk_cfg(1, 1, 0, 0, 0); tick();
    for (int i = 0; i < 8; i++) begin
      data = (i == 5) ? (w ^ 32'd1) : w;
      if (i == 5) bad = data;
      valid = 1'b1; tick();
      if (i == 4) check("lfsr_err_before", 32'(err), 0);
      if (i == 5) begin
        check("lfsr_err_latency", 32'(err), 1);
        check("lfsr_ec_latency", 32'(ec), 1);
      end
      w = ref_lfsr(w);
    end
    valid = 1'b0;
    check("lfsr_ec", 32'(ec), 1);
    check("lfsr_fidx", 32'(fidx), 5);
    check("lfsr_fdata", fdata, bad);
    check("lfsr_wc", 32'(wc), 8);
    check("lfsr_busy", 32'(busy), 1);
    check("lfsr_ready", 32'(ready), 1);
    idle_and_clear();

    // ---------------- stop_on_err ----------------
    cfg = mk_cfg(1, 0, 1, 0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      data = (i == 3) ? (32'd4 ^ 32'h10) : 32'(i + 1);
      valid = 1'b1; tick();
    end
    check("halt_ready", 32'(ready), 0);
    check("halt_busy", 32'(busy), 1);
    check("halt_wc", 32'(wc), 4);
    check("halt_err", 32'(err), 1);
    check("halt_fidx", 32'(fidx), 3);
    tick();
    check("halt_wc_hold", 32'(wc), 4);
    valid = 1'b0;
    cfg = mk_cfg(0, 0, 1, 0, 0); tick();
    check("halt_exit_busy", 32'(busy), 0);
    cfg = mk_cfg(0, 0, 0, 1, 0); tick();
    cfg = mk_cfg(0, 0, 0, 0, 0);
    check_all_zero("halt_clr");

    // ---------------- en dropped during a transfer ----------------
    cfg = mk_cfg(1, 0, 0, 0, 0); tick();
    data = 32'd1; valid = 1'b1; tick();
    cfg = mk_cfg(0, 0, 0, 0, 0); data = 32'd2; tick();
    valid = 1'b0;
    check("endrop_wc", 32'(wc), 2);
    check("endrop_ec", 32'(ec), 0);
    check("endrop_ready", 32'(ready), 0);
    check("endrop_busy", 32'(busy), 0);

    // ---------------- reset mid-stream ----------------
    cfg = mk_cfg(1, 0, 0, 0, 0); tick();
    data = 32'd1; valid = 1'b1; tick();
    data = 32'd7; tick();
    data = 32'd3; rst = 1'b1; cfg = 0; tick();
    rst = 1'b0; valid = 1'b0;
    check_all_zero("midrst");

    // ---------------- wrap + saturation table (CNT_W = 4) ----------------
    cfg4 = mk_cfg(1, 0, 0, 0, 0); tick();
    for (int i = 0; i < 20; i++) begin
      data4 = tbl[i].data; valid4 = 1'b1; tick();
      check($sformatf("wrap_wc_%0d", i), 32'(wc4), 32'(tbl[i].exp_wc));
      check($sformatf("wrap_ec_%0d", i), 32'(ec4), 0);
    end
    valid4 = 1'b0;
    check("wrap_err", 32'(err4), 0);

    // ---------------- randomized against model ----------------
    idle_and_clear();
    m_wc = 0; m_ec = 0; m_err = 0; m_fidx = 0; m_fdata = 0;
    for (int seg = 0; seg < 6; seg++) begin
      if (seg != 0 && $urandom_range(0, 1) == 1) begin
        idle_and_clear();
        m_wc = 0; m_ec = 0; m_err = 0; m_fidx = 0; m_fdata = 0;
      end
      mode = 1'($urandom_range(0, 1));
      cfg = mk_cfg(1, mode, 0, 0, 0); tick();
      exp_q.delete();
      w = 32'd1;
      for (int k = 0; k < 64; k++) begin
        exp_q.push_back(w);
        w = mode ? ref_lfsr(w) : w + 32'd1;
      end
      for (int c = 0; c < 40; c++) begin
        // clr and mode are ignored while running; poke them at random
        cfg = mk_cfg(1, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), 0);
        valid = 1'($urandom_range(0, 1));
        e = exp_q[0];
        data = ($urandom_range(0, 5) == 0) ? (e ^ ($urandom() | 32'h1)) : e;
        if (!valid) data = $urandom();
        check("rand_ready", 32'(ready), 1);
        tick();
        if (valid) begin
          void'(exp_q.pop_front());
          if (data != e) begin
            m_ec = sat16(m_ec + 1);
            if (!m_err) begin
              m_fidx = m_wc;
              m_fdata = data;
            end
            m_err = 1'b1;
          end
          m_wc = sat16(m_wc + 1);
        end
        check("rand_wc", 32'(wc), 32'(m_wc));
        check("rand_ec", 32'(ec), 32'(m_ec));
        check("rand_err", 32'(err), 32'(m_err));
        check("rand_fidx", 32'(fidx), 32'(m_fidx));
        check("rand_fdata", fdata, m_fdata);
      end
      valid = 1'b0;
      cfg = mk_cfg(0, 0, 0, 0, 0); tick();
    end

    // ---------------- stall period 3, valid held 16 cycles ----------------
    idle_and_clear();
    acc = 0;
    cfg = mk_cfg(1, 0, 0, 0, 8'd3); tick();
    for (int c = 0; c < 16; c++) begin
`ifdef UDMA_EXT_PER_CHK_STALL_EN
      exp_rdy = ((c % 4) != 3);
`else
      exp_rdy = 1'b1;
`endif
      data = 32'(acc + 1); valid = 1'b1;
      check($sformatf("stall_ready_%0d", c), 32'(ready), 32'(exp_rdy));
      tick();
      if (exp_rdy) acc++;
    end
    valid = 1'b0;
`ifdef UDMA_EXT_PER_CHK_STALL_EN
    check("stall_wc", 32'(wc), 12);
`else
    check("stall_wc", 32'(wc), 16);
`endif
    check("stall_ec", 32'(ec), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
